demux7_reg: RTL

DEMUX7_REG -- requirements
Module: demux7_reg

---
 rtl/demux7_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/demux7_reg.sv
// Registered 1-to-7 demux: holds one word and presents it on out0..out6, flagging destinations via out_valid.
// Latency 1 cycle accept-to-out_valid; 1 word/cycle sustained when destinations are ready.
// Backpressure: in_ready drops while any pending destination stalls; DEMUX_BCAST_EN makes select 7 broadcast.
`ifndef DataWidth
`define DataWidth 8
`endif

module demux7_reg #(
    parameter int DEMUXWIDTH = `DataWidth
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEMUXWIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic [2:0]            select,
    output logic                  in_ready,
    output logic [DEMUXWIDTH-1:0] out0,
    output logic [DEMUXWIDTH-1:0] out1,
    output logic [DEMUXWIDTH-1:0] out2,
    output logic [DEMUXWIDTH-1:0] out3,
    output logic [DEMUXWIDTH-1:0] out4,
    output logic [DEMUXWIDTH-1:0] out5,
    output logic [DEMUXWIDTH-1:0] out6,
    output logic [6:0]            out_valid,
    input  logic [6:0]            out_ready
);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                state, state_nxt;
    logic [6:0]            pending, pending_nxt;
    logic [DEMUXWIDTH-1:0] held, held_nxt;
    logic [6:0]            remaining;
    logic                  accept;

    function automatic logic [6:0] decode(input logic [2:0] s);
        logic [6:0] m;
        m = 7'd0;
        if (s == 3'd7) begin
`ifdef DEMUX_BCAST_EN
            m = 7'h7F;
`else
            m = 7'b100_0000;
`endif
        end else begin
            m = 7'd1 << s;
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            pending <= 7'd0;
            held    <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            held    <= held_nxt;
        end
    end

    // Destinations still owed the held word after this cycle's handshakes.
    assign remaining = pending & ~out_ready;
    assign in_ready  = (state == EMPTY) || (remaining == 7'd0);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        held_nxt    = held;
        if (accept) begin
            held_nxt    = in_data;
            pending_nxt = decode(select);
            state_nxt   = HOLD;
        end else if (state == HOLD) begin
            pending_nxt = remaining;
            state_nxt   = (remaining == 7'd0) ? EMPTY : HOLD;
        end
    end

    assign out_valid = pending;
    assign out0      = held;
    assign out1      = held;
    assign out2      = held;
    assign out3      = held;
    assign out4      = held;
    assign out5      = held;
    assign out6      = held;

endmodule
